// File: rtl/fb_vport_pkg.sv
// Shared types for the framebuffer video port: FSM states, FIFO entry layout
// and the RGB555 -> RGB888 expansion.
package fb_vport_pkg;

  localparam int ENTRY_W = 16;

  typedef enum logic [1:0] {SEEK, ARMED, RUN} vpState_e;

  typedef struct packed {
    logic        start;
    logic [14:0] pix;
  } fifoEntry_t;

  // Replicate the top bits into the low bits so full-scale 5-bit maps to 0xFF.
  function automatic logic [23:0] expand555(input logic [14:0] p);
    return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/fb_vport_timing_if.sv
// Pixel stream in and DVI-side video out of fb_vport_timing.
interface fb_vport_timing_if;
  logic [14:0] iST_DATA;
  logic        iST_START;
  logic        iST_DV;
  logic        oST_READY;
  logic [7:0]  oRED, oGRN, oBLU;
  logic        oHS, oVS, oDE;
  logic        oUNDERRUN;
  logic        oLOCKED;

  modport master (
    output iST_DATA, iST_START, iST_DV,
    input  oST_READY, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERRUN, oLOCKED
  );

  modport slave (
    input  iST_DATA, iST_START, iST_DV,
    output oST_READY, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERRUN, oLOCKED
  );
endinterface

// File: rtl/fb_pixel_fifo.sv
// Single-clock show-ahead FIFO; the head entry is readable while count != 0.
module fb_pixel_fifo
  import fb_vport_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic                     iCLK,
  input  logic                     iRESETn,
  input  logic                     wrEn,
  input  logic [W-1:0]             wrData,
  input  logic                     rdEn,
  output logic [W-1:0]             headData,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;

  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      unique case ({wrEn, rdEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/fb_vport_timing.sv
// Raster timing generator that re-times a buffered RGB555 stream onto it,
// locking each frame's start pixel to raster origin and relocking after faults.
module fb_vport_timing
  import fb_vport_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input logic              iCLK,
  input logic              iRESETn,
  fb_vport_timing_if.slave vp
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          deRaw, origin, hsAct, vsAct;

  vpState_e      state;
  fifoEntry_t    head;
  logic [CW-1:0] fifoCnt;
  logic          fifoEmpty, fifoWr, pop, fault;

  logic [23:0]   rgbQ;
  logic          hsQ, vsQ, deQ, undQ, lockQ, readyQ;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign deRaw  = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign origin = (hcnt == '0) && (vcnt == '0);
  assign hsAct  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vsAct  = (vcnt >= VS_BEG) && (vcnt < VS_END);

  assign fifoWr    = vp.iST_DV && readyQ;
  assign fifoEmpty = (fifoCnt == '0);

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) uFifo (
    .iCLK     (iCLK),
    .iRESETn  (iRESETn),
    .wrEn     (fifoWr),
    .wrData   ({vp.iST_START, vp.iST_DATA}),
    .rdEn     (pop),
    .headData (head),
    .count    (fifoCnt)
  );

  // A start marker anywhere but origin means the stream and raster disagree.
  assign fault = (state == RUN) && deRaw && (fifoEmpty || (head.start && !origin));

  always_comb begin
    pop = 1'b0;
    unique case (state)
      SEEK:    pop = !fifoEmpty && !head.start;
      ARMED:   pop = origin && !fifoEmpty;
      RUN:     pop = deRaw && !fault;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state  <= SEEK;
      rgbQ   <= '0;
      hsQ    <= ~SYNC_POL;
      vsQ    <= ~SYNC_POL;
      deQ    <= 1'b0;
      undQ   <= 1'b0;
      lockQ  <= 1'b0;
      readyQ <= 1'b0;
    end else begin
      readyQ <= (fifoCnt <= READY_MAX);
      deQ    <= deRaw;
      hsQ    <= hsAct ? SYNC_POL : ~SYNC_POL;
      vsQ    <= vsAct ? SYNC_POL : ~SYNC_POL;
      rgbQ   <= '0;
      undQ   <= 1'b0;
      unique case (state)
        SEEK: if (!fifoEmpty && head.start) state <= ARMED;
        ARMED: if (origin) begin
          state <= RUN;
          lockQ <= 1'b1;
          rgbQ  <= expand555(head.pix);
        end
        RUN: if (fault) begin
          state <= SEEK;
          lockQ <= 1'b0;
          undQ  <= 1'b1;
        end else if (pop) begin
          rgbQ <= expand555(head.pix);
        end
        default: state <= SEEK;
      endcase
    end
  end

  assign vp.oRED      = rgbQ[23:16];
  assign vp.oGRN      = rgbQ[15:8];
  assign vp.oBLU      = rgbQ[7:0];
  assign vp.oHS       = hsQ;
  assign vp.oVS       = vsQ;
  assign vp.oDE       = deQ;
  assign vp.oUNDERRUN = undQ;
  assign vp.oLOCKED   = lockQ;
  assign vp.oST_READY = readyQ;

endmodule

// File: tb/tb_fb_vport_timing.sv
// Bench for fb_vport_timing: small-raster DUT against a queue-based frame model,
// plus a default-parameter DUT for sync position and async reset.
module tb_fb_vport_timing;
  localparam int HA = 4, HF = 1, HSY = 1, HB = 1;
  localparam int VA = 2, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  always #5 clk = ~clk;

  fb_vport_timing_if vp ();
  fb_vport_timing_if vp2 ();

  fb_vport_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0), .FIFO_DEPTH(DEPTH)
  ) dut (.iCLK(clk), .iRESETn(rst_n), .vp(vp));

  fb_vport_timing dut2 (.iCLK(clk), .iRESETn(rst2_n), .vp(vp2));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp555(input logic [14:0] p);
    int r, g, b;
    r = (int'(p) >> 10) & 31;
    g = (int'(p) >> 5) & 31;
    b = int'(p) & 31;
    return 24'((((r * 8) + (r / 4)) << 16) | (((g * 8) + (g / 4)) << 8) | ((b * 8) + (b / 4)));
  endfunction

  function automatic logic [14:0] patAt(input int i);
    case (i % 4)
      0:       return 15'h7FFF;
      1:       return 15'h7C00;
      2:       return 15'h03E0;
      default: return 15'h001F;
    endcase
  endfunction

  // Source side: queue of {start,pixel}; driven at negedge, popped once accepted.
  logic [15:0] srcQ[$];
  bit          gateAll = 1'b0, accepted = 1'b0;

  task automatic pushFrame(input int n, input bit rnd);
    logic [14:0] p;
    for (int i = 0; i < n; i++) begin
      p = rnd ? 15'($urandom_range(0, 32767)) : patAt(i);
      srcQ.push_back({(i == 0), p});
    end
  endtask

  always @(negedge clk) begin
    if (accepted) begin
      void'(srcQ.pop_front());
      accepted = 1'b0;
    end
    if (srcQ.size() > 0 && (gateAll || $urandom_range(0, 3) != 0)) begin
      vp.iST_DV = 1'b1;
      {vp.iST_START, vp.iST_DATA} = srcQ[0];
    end else begin
      vp.iST_DV = 1'b0;
      vp.iST_START = 1'b0;
      vp.iST_DATA = '0;
    end
  end

  // Frame model: raster position from elapsed cycles, FIFO as a queue,
  // locked/armed flags for the lock sequence.
  logic [15:0] mq[$];
  logic [15:0] mTop;
  int          tcnt, mh, mv, msz;
  bit          mLocked, mArmed, mOrg;
  logic [23:0] eRgb;
  bit          eHs, eVs, eDe, eUnd, eLock, eReady;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      tcnt = 0; mLocked = 0; mArmed = 0; accepted = 0;
      eRgb = '0; eHs = 1; eVs = 1; eDe = 0; eUnd = 0; eLock = 0; eReady = 0;
    end else begin
      mh = tcnt % HT;
      mv = (tcnt / HT) % VT;
      tcnt++;
      mOrg = (mh == 0 && mv == 0);
      msz = mq.size();
      eDe = (mh < HA && mv < VA);
      eHs = !(mh >= HA + HF && mh < HA + HF + HSY);
      eVs = !(mv >= VA + VF && mv < VA + VF + VSY);
      eRgb = '0;
      eUnd = 0;
      if (mLocked) begin
        if (eDe) begin
          if (msz == 0 || (mq[0][15] && !mOrg)) begin
            eUnd = 1; mLocked = 0;
          end else begin
            mTop = mq.pop_front();
            eRgb = exp555(mTop[14:0]);
          end
        end
      end else if (mArmed) begin
        if (mOrg) begin
          mTop = mq.pop_front();
          eRgb = exp555(mTop[14:0]);
          mLocked = 1; mArmed = 0;
        end
      end else if (msz > 0) begin
        if (mq[0][15]) mArmed = 1;
        else void'(mq.pop_front());
      end
      accepted = vp.iST_DV && eReady;
      if (accepted) mq.push_back({vp.iST_START, vp.iST_DATA});
      eReady = (msz <= DEPTH - 2);
      eLock = mLocked;
    end
  end

  always @(negedge clk) begin
    if (rst_n)
      chk("outputs_vs_model",
          {vp.oRED, vp.oGRN, vp.oBLU, vp.oHS, vp.oVS, vp.oDE, vp.oUNDERRUN, vp.oLOCKED, vp.oST_READY},
          {eRgb, eHs, eVs, eDe, eUnd, eLock, eReady});
  end

  bit monReady = 0, sawHi = 0, sawLo = 0;
  always @(negedge clk) begin
    if (rst_n && monReady) begin
      if (vp.oST_READY) sawHi = 1;
      else sawLo = 1;
    end
  end

  task automatic waitLockDe(output logic [23:0] px, output bit ok);
    ok = 0;
    px = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vp.oDE && vp.oLOCKED) begin
        ok = 1;
        px = {vp.oRED, vp.oGRN, vp.oBLU};
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int          hsLo, vsLo, deHi, rgbNz, lockHi, lockLo, undCnt, n, k;
  logic [24:0] undPx;
  logic [23:0] px;
  bit          ok, preLock;

  initial begin
    vp2.iST_DV = 1'b0; vp2.iST_START = 1'b0; vp2.iST_DATA = '0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {vp.oRED, vp.oGRN, vp.oBLU, vp.oHS, vp.oVS, vp.oDE, vp.oUNDERRUN, vp.oLOCKED, vp.oST_READY},
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Free-running counters, no stream: any 35-cycle window is one frame.
    repeat (10) @(negedge clk);
    hsLo = 0; vsLo = 0; deHi = 0; rgbNz = 0; lockHi = 0;
    for (int i = 0; i < HT * VT; i++) begin
      @(negedge clk);
      if (!vp.oHS) hsLo++;
      if (!vp.oVS) vsLo++;
      if (vp.oDE) deHi++;
      if ({vp.oRED, vp.oGRN, vp.oBLU} != 24'h0) rgbNz++;
      if (vp.oLOCKED) lockHi++;
    end
    chk("hs_low_per_frame", hsLo, 5);
    chk("vs_low_per_frame", vsLo, 7);
    chk("de_high_per_frame", deHi, 8);
    chk("idle_rgb_nonzero", rgbNz, 0);
    chk("idle_locked", lockHi, 0);

    // Pattern frames with DV held high.
    gateAll = 1; monReady = 1;
    repeat (6) pushFrame(8, 0);
    waitLockDe(px, ok);
    chk("lock_seen", ok, 1);
    chk("first_pixel", px, 24'hFFFFFF);
    @(negedge clk);
    chk("second_pixel", {vp.oRED, vp.oGRN, vp.oBLU}, 24'hFF0000);
    lockLo = 0;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      @(negedge clk);
      if (!vp.oLOCKED) lockLo++;
    end
    chk("locked_3_frames", lockLo, 0);
    monReady = 0;
    chk("ready_toggles", {sawHi, sawLo}, 2'b11);

    // Truncated frame: underrun on its 6th DE, then relock.
    for (int i = 0; i < 2000 && srcQ.size() > 0; i++) @(negedge clk);
    pushFrame(5, 0);
    undCnt = 0; undPx = '1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vp.oUNDERRUN) begin
        undCnt++;
        undPx = {vp.oRED, vp.oGRN, vp.oBLU, vp.oDE};
      end
    end
    chk("underrun_pulses", undCnt, 1);
    chk("underrun_black_de", undPx, {24'h0, 1'b1});
    chk("locked_fell", vp.oLOCKED, 0);
    gateAll = 0;
    repeat (3) pushFrame(8, 0);
    waitLockDe(px, ok);
    chk("relock", ok, 1);
    chk("relock_first_pixel", px, 24'hFFFFFF);

    // Async reset mid-frame while locked.
    repeat (10) @(negedge clk);
    preLock = vp.oLOCKED;
    chk("locked_before_reset", preLock, 1);
    #2 rst_n = 1'b0;
    srcQ.delete();
    #1;
    chk("async_reset_values",
        {vp.oRED, vp.oGRN, vp.oBLU, vp.oHS, vp.oVS, vp.oDE, vp.oUNDERRUN, vp.oLOCKED, vp.oST_READY},
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Junk without start must be dropped; first shown pixel is the start pixel.
    repeat (5) @(negedge clk);
    srcQ.push_back({1'b0, 15'h0421});
    srcQ.push_back({1'b0, 15'h1234});
    srcQ.push_back({1'b0, 15'h2A5A});
    repeat (2) pushFrame(8, 0);
    waitLockDe(px, ok);
    chk("junk_lock_seen", ok, 1);
    chk("first_after_junk", px, 24'hFFFFFF);

    // Randomized frames: random pixels, occasional short/long frames and gaps.
    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 10)) : 8;
      pushFrame(n, 1);
      for (int i = 0; i < 500 && srcQ.size() > 12; i++) @(negedge clk);
      if ($urandom_range(0, 6) == 0) begin
        for (int i = 0; i < 500 && srcQ.size() > 0; i++) @(negedge clk);
        repeat ($urandom_range(20, 80)) @(negedge clk);
      end
    end
    for (int i = 0; i < 2000 && srcQ.size() > 0; i++) @(negedge clk);
    chk("random_src_drained", srcQ.size(), 0);
    repeat (80) @(negedge clk);

    // Default raster: HS asserts for hcnt 656, visible one registered cycle later.
    @(negedge clk);
    rst2_n = 1'b1;
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      k++;
      if (!vp2.oHS) break;
    end
    chk("hs_first_edge", k, 657);
    repeat (50) @(negedge clk);
    chk("dut2_ready_before_reset", {vp2.oST_READY, vp2.oHS}, 2'b10);
    #2 rst2_n = 1'b0;
    #1;
    chk("dut2_async_reset",
        {vp2.oRED, vp2.oGRN, vp2.oBLU, vp2.oHS, vp2.oVS, vp2.oDE, vp2.oUNDERRUN, vp2.oLOCKED, vp2.oST_READY},
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
